decode: RTL and testbench

//  Instruction-decode / operand-fetch stage, directly upstream of execute. Takes one fetched

---
 rtl/decode_pkg.sv | 72 +++++++
 rtl/decode_regfile.sv | 40 ++++
 rtl/decode.sv | 136 +++++++++++++
 tb/tb_decode.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage and its neighbours (fetch, execute).
// Holds datapath widths, instruction class codes, one-hot unit select bit
// positions, instruction field offsets and small decode helper functions.
package decode_pkg;

   localparam int WORD   = 32;
   localparam int ADDR   = 32;
   localparam int W_RD   = 4;
   localparam int W_DOPC = 6;
   localparam int W_OPC  = 4;

   // Instruction class codes carried in the top three instruction bits.
   // Codes 6 and 7 are unassigned and decode as illegal.
   typedef enum logic [2:0] {
      CLS_INTE   = 3'd0,
      CLS_SHIFT  = 3'd1,
      CLS_LOGIC  = 3'd2,
      CLS_LOAD   = 3'd3,
      CLS_STORE  = 3'd4,
      CLS_BRANCH = 3'd5,
      CLS_ILL6   = 3'd6,
      CLS_ILL7   = 3'd7
   } inst_class_e;

   // Bit positions of the execute unit select, MSB..LSB.
   localparam int DOPC_INTE   = 5;
   localparam int DOPC_SHIFT  = 4;
   localparam int DOPC_LOGIC  = 3;
   localparam int DOPC_LOAD   = 2;
   localparam int DOPC_STORE  = 1;
   localparam int DOPC_BRANCH = 0;

   // Instruction field offsets.
   localparam int F_CLS_HI   = 31;
   localparam int F_CLS_LO   = 29;
   localparam int F_IMM      = 28;
   localparam int F_OPC_HI   = 27;
   localparam int F_OPC_LO   = 24;
   localparam int F_RD_HI    = 23;
   localparam int F_RD_LO    = 20;
   localparam int F_RS_HI    = 19;
   localparam int F_RS_LO    = 16;
   localparam int F_IMM16_HI = 15;
   localparam int F_IMM16_LO = 0;

   // One-hot unit select for a class; illegal classes select no unit.
   function automatic logic [W_DOPC-1:0] class_to_dopc(input inst_class_e cls);
      logic [W_DOPC-1:0] d;
      d = '0;
      case (cls)
         CLS_INTE:   d[DOPC_INTE]   = 1'b1;
         CLS_SHIFT:  d[DOPC_SHIFT]  = 1'b1;
         CLS_LOGIC:  d[DOPC_LOGIC]  = 1'b1;
         CLS_LOAD:   d[DOPC_LOAD]   = 1'b1;
         CLS_STORE:  d[DOPC_STORE]  = 1'b1;
         CLS_BRANCH: d[DOPC_BRANCH] = 1'b1;
         default:    d = '0;
      endcase
      return d;
   endfunction

   // Only the arithmetic/shift/logic/load units produce a register result.
   function automatic logic class_writes_rd(input inst_class_e cls);
      return (cls == CLS_INTE) || (cls == CLS_SHIFT) ||
             (cls == CLS_LOGIC) || (cls == CLS_LOAD);
   endfunction

   function automatic logic [WORD-1:0] sext16(input logic [15:0] v);
      return {{(WORD-16){v[15]}}, v};
   endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file owned by the decode stage: 2**W_RD entries of WORD bits,
// two asynchronous read ports and one synchronous write port.
// Synchronous active-high reset clears every entry.
// Ports:
//   clk, rst            clock, synchronous reset
//   we, waddr, wdata    write port (committed write-back from execute)
//   raddr_a / rdata_a   read port A (rs operand)
//   raddr_b / rdata_b   read port B (rd operand)
module decode_regfile
   import decode_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [W_RD-1:0] waddr,
   input  logic [WORD-1:0] wdata,
   input  logic [W_RD-1:0] raddr_a,
   output logic [WORD-1:0] rdata_a,
   input  logic [W_RD-1:0] raddr_b,
   output logic [WORD-1:0] rdata_b
);

   localparam int NREG = 2 ** W_RD;

   logic [WORD-1:0] mem [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/decode.sv
// Instruction-decode / operand-fetch stage sitting directly ahead of execute.
// Decodes one instruction per cycle into a one-hot unit select and sub-opcode,
// reads operands from its own register file (with write-back bypass), and
// registers everything into execute. Interlocks on a one-deep RAW hazard
// against the instruction currently held in its output register.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   v_i, inst_i, addr_i          fetched instruction
//   stall_o                      tells fetch to hold its outputs
//   flush_i                      kill input and output-register instruction
//   ex_stall_i                   execute is stalled
//   v_o, src_o, dest_o, wb_o,
//   rd_num_o, dopc_o, opc_o,
//   origaddr_o, illegal_o        registered decoded instruction to execute
//   ex_wb_i, ex_rd_num_i,
//   ex_rd_data_i                 committed write-back from execute
module decode
   import decode_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              v_i,
   input  logic [WORD-1:0]   inst_i,
   input  logic [ADDR-1:0]   addr_i,
   output logic              stall_o,
   input  logic              flush_i,
   input  logic              ex_stall_i,
   output logic              v_o,
   output logic [WORD-1:0]   src_o,
   output logic [WORD-1:0]   dest_o,
   output logic              wb_o,
   output logic [W_RD-1:0]   rd_num_o,
   output logic [W_DOPC-1:0] dopc_o,
   output logic [W_OPC-1:0]  opc_o,
   output logic [ADDR-1:0]   origaddr_o,
   output logic              illegal_o,
   input  logic              ex_wb_i,
   input  logic [W_RD-1:0]   ex_rd_num_i,
   input  logic [WORD-1:0]   ex_rd_data_i
);

   inst_class_e       in_cls;
   logic              in_imm;
   logic [W_OPC-1:0]  in_opc;
   logic [W_RD-1:0]   in_rd;
   logic [W_RD-1:0]   in_rs;
   logic [15:0]       in_imm16;
   logic              in_legal;
   logic              in_writes;
   logic [W_DOPC-1:0] in_dopc;

   logic [WORD-1:0]   rf_rs;
   logic [WORD-1:0]   rf_rd;
   logic [WORD-1:0]   rs_val;
   logic [WORD-1:0]   rd_val;
   logic [WORD-1:0]   src_next;
   logic              hazard;

   assign in_cls    = inst_class_e'(inst_i[F_CLS_HI:F_CLS_LO]);
   assign in_imm    = inst_i[F_IMM];
   assign in_opc    = inst_i[F_OPC_HI:F_OPC_LO];
   assign in_rd     = inst_i[F_RD_HI:F_RD_LO];
   assign in_rs     = inst_i[F_RS_HI:F_RS_LO];
   assign in_imm16  = inst_i[F_IMM16_HI:F_IMM16_LO];
   assign in_legal  = (in_cls != CLS_ILL6) && (in_cls != CLS_ILL7);
   assign in_writes = class_writes_rd(in_cls);
   assign in_dopc   = class_to_dopc(in_cls);

   decode_regfile u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (ex_wb_i),
      .waddr   (ex_rd_num_i),
      .wdata   (ex_rd_data_i),
      .raddr_a (in_rs),
      .rdata_a (rf_rs),
      .raddr_b (in_rd),
      .rdata_b (rf_rd)
   );

   // The register file only updates at the edge, so a value being written
   // back this cycle must be forwarded around it.
   assign rs_val   = (ex_wb_i && (ex_rd_num_i == in_rs)) ? ex_rd_data_i : rf_rs;
   assign rd_val   = (ex_wb_i && (ex_rd_num_i == in_rd)) ? ex_rd_data_i : rf_rd;
   assign src_next = in_imm ? sext16(in_imm16) : rs_val;

   // The instruction in the output register has not written back yet, so a
   // reader of its destination must wait one cycle; by then the result is on
   // the write-back bus and the bypass supplies it. rd is always read (store
   // data / branch operand), rs only in register form. Illegal instructions
   // read nothing and therefore never interlock.
   assign hazard = v_i && v_o && wb_o && in_legal &&
                   ((in_rd == rd_num_o) || (!in_imm && (in_rs == rd_num_o)));

   assign stall_o = !flush_i && (ex_stall_i || hazard);

   // Output register: flush beats execute stall, which beats the hazard
   // bubble. Only the valid-type flags are cleared for a bubble or flush;
   // the payload fields are don't-care while v_o is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_o        <= 1'b0;
         wb_o       <= 1'b0;
         illegal_o  <= 1'b0;
         src_o      <= '0;
         dest_o     <= '0;
         rd_num_o   <= '0;
         dopc_o     <= '0;
         opc_o      <= '0;
         origaddr_o <= '0;
      end else if (flush_i) begin
         v_o       <= 1'b0;
         wb_o      <= 1'b0;
         illegal_o <= 1'b0;
      end else if (ex_stall_i) begin
         v_o       <= v_o;
         wb_o      <= wb_o;
         illegal_o <= illegal_o;
      end else if (hazard) begin
         v_o       <= 1'b0;
         wb_o      <= 1'b0;
         illegal_o <= 1'b0;
      end else begin
         v_o        <= v_i;
         wb_o       <= v_i && in_writes;
         illegal_o  <= v_i && !in_legal;
         src_o      <= src_next;
         dest_o     <= rd_val;
         rd_num_o   <= in_rd;
         dopc_o     <= in_dopc;
         opc_o      <= in_opc;
         origaddr_o <= addr_i;
      end
   end

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for the decode stage. Execute is modelled by
// driving the write-back bus by hand at the cycle a real execute would.
module tb_decode;

   logic        clk;
   logic        rst;
   logic        v_i;
   logic [31:0] inst_i;
   logic [31:0] addr_i;
   logic        stall_o;
   logic        flush_i;
   logic        ex_stall_i;
   logic        v_o;
   logic [31:0] src_o;
   logic [31:0] dest_o;
   logic        wb_o;
   logic [3:0]  rd_num_o;
   logic [5:0]  dopc_o;
   logic [3:0]  opc_o;
   logic [31:0] origaddr_o;
   logic        illegal_o;
   logic        ex_wb_i;
   logic [3:0]  ex_rd_num_i;
   logic [31:0] ex_rd_data_i;

   int n_cmp = 0;
   int n_err = 0;

   decode dut (
      .clk          (clk),
      .rst          (rst),
      .v_i          (v_i),
      .inst_i       (inst_i),
      .addr_i       (addr_i),
      .stall_o      (stall_o),
      .flush_i      (flush_i),
      .ex_stall_i   (ex_stall_i),
      .v_o          (v_o),
      .src_o        (src_o),
      .dest_o       (dest_o),
      .wb_o         (wb_o),
      .rd_num_o     (rd_num_o),
      .dopc_o       (dopc_o),
      .opc_o        (opc_o),
      .origaddr_o   (origaddr_o),
      .illegal_o    (illegal_o),
      .ex_wb_i      (ex_wb_i),
      .ex_rd_num_i  (ex_rd_num_i),
      .ex_rd_data_i (ex_rd_data_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [2:0] c, input logic imm,
                                      input logic [3:0] opc, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [15:0] i16);
      return {c, imm, opc, rd, rs, i16};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; v_i = 1'b1; inst_i = mk(3'd0, 1'b1, 4'd3, 4'd2, 4'd1, 16'h1234);
      addr_i = 32'h0000_0040;
      tick(); tick();
      n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_v_o got %0b want 0", v_o); end
      n_cmp++; if (wb_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_wb_o got %0b want 0", wb_o); end
      n_cmp++; if (illegal_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_illegal_o got %0b want 0", illegal_o); end
      n_cmp++; if (dopc_o !== 6'b0) begin n_err++; $display("[TB] FAIL reset_dopc_o got %b want 000000", dopc_o); end
      n_cmp++; if (src_o !== 32'h0) begin n_err++; $display("[TB] FAIL reset_src_o got %h want 0", src_o); end
      n_cmp++; if (dest_o !== 32'h0) begin n_err++; $display("[TB] FAIL reset_dest_o got %h want 0", dest_o); end
      n_cmp++; if (rd_num_o !== 4'h0) begin n_err++; $display("[TB] FAIL reset_rd_num_o got %0d want 0", rd_num_o); end
      n_cmp++; if (opc_o !== 4'h0) begin n_err++; $display("[TB] FAIL reset_opc_o got %0d want 0", opc_o); end
      n_cmp++; if (origaddr_o !== 32'h0) begin n_err++; $display("[TB] FAIL reset_origaddr_o got %h want 0", origaddr_o); end
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_stall_o got %0b want 0", stall_o); end
      rst = 1'b0;
      // Read every register through stores (no write-back, so no interlock).
      for (int i = 0; i < 16; i++) begin
         inst_i = mk(3'd4, 1'b0, 4'd0, 4'(i), 4'(15 - i), 16'h0);
         addr_i = 32'h1000 + 32'(i * 4);
         tick();
         n_cmp++; if (src_o !== 32'h0) begin n_err++; $display("[TB] FAIL reset_rf_rs R%0d got %h want 0", 15 - i, src_o); end
         n_cmp++; if (dest_o !== 32'h0) begin n_err++; $display("[TB] FAIL reset_rf_rd R%0d got %h want 0", i, dest_o); end
      end
      v_i = 1'b0;
      tick();
   endtask

   task automatic test_decode();
      // Preload R3 through the write-back port.
      ex_wb_i = 1'b1; ex_rd_num_i = 4'd3; ex_rd_data_i = 32'h0000_1234;
      tick();
      ex_wb_i = 1'b0;
      v_i = 1'b1; inst_i = mk(3'd0, 1'b1, 4'd3, 4'd2, 4'd0, 16'hFFFE); addr_i = 32'h100;
      tick();
      n_cmp++; if (v_o !== 1'b1) begin n_err++; $display("[TB] FAIL dec_inte_v_o got %0b want 1", v_o); end
      n_cmp++; if (dopc_o !== 6'b100000) begin n_err++; $display("[TB] FAIL dec_inte_dopc got %b want 100000", dopc_o); end
      n_cmp++; if (opc_o !== 4'd3) begin n_err++; $display("[TB] FAIL dec_inte_opc got %0d want 3", opc_o); end
      n_cmp++; if (src_o !== 32'hFFFF_FFFE) begin n_err++; $display("[TB] FAIL dec_inte_src got %h want fffffffe", src_o); end
      n_cmp++; if (wb_o !== 1'b1) begin n_err++; $display("[TB] FAIL dec_inte_wb got %0b want 1", wb_o); end
      n_cmp++; if (rd_num_o !== 4'd2) begin n_err++; $display("[TB] FAIL dec_inte_rd_num got %0d want 2", rd_num_o); end
      n_cmp++; if (origaddr_o !== 32'h100) begin n_err++; $display("[TB] FAIL dec_inte_addr got %h want 100", origaddr_o); end
      // Store, reg form; R7 written the same cycle must be bypassed onto dest.
      inst_i = mk(3'd4, 1'b0, 4'd9, 4'd7, 4'd3, 16'h0); addr_i = 32'h104;
      ex_wb_i = 1'b1; ex_rd_num_i = 4'd7; ex_rd_data_i = 32'hABCD_0000;
      tick();
      ex_wb_i = 1'b0;
      n_cmp++; if (dopc_o !== 6'b000010) begin n_err++; $display("[TB] FAIL dec_store_dopc got %b want 000010", dopc_o); end
      n_cmp++; if (wb_o !== 1'b0) begin n_err++; $display("[TB] FAIL dec_store_wb got %0b want 0", wb_o); end
      n_cmp++; if (src_o !== 32'h0000_1234) begin n_err++; $display("[TB] FAIL dec_store_src got %h want 00001234", src_o); end
      n_cmp++; if (dest_o !== 32'hABCD_0000) begin n_err++; $display("[TB] FAIL dec_store_dest_bypass got %h want abcd0000", dest_o); end
      n_cmp++; if (opc_o !== 4'd9) begin n_err++; $display("[TB] FAIL dec_store_opc got %0d want 9", opc_o); end
      // Every legal class: one-hot select and write-back flag.
      for (int c = 0; c < 6; c++) begin
         logic [5:0] exp_dopc;
         logic       exp_wb;
         exp_dopc = 6'b100000 >> c;
         exp_wb   = (c < 4);
         inst_i = mk(3'(c), 1'b1, 4'(c), 4'(8 + c), 4'd0, 16'(c));
         addr_i = 32'h110 + 32'(c * 4);
         tick();
         n_cmp++; if (dopc_o !== exp_dopc) begin n_err++; $display("[TB] FAIL dec_class%0d_dopc got %b want %b", c, dopc_o, exp_dopc); end
         n_cmp++; if (wb_o !== exp_wb) begin n_err++; $display("[TB] FAIL dec_class%0d_wb got %0b want %0b", c, wb_o, exp_wb); end
         n_cmp++; if (src_o !== 32'(c)) begin n_err++; $display("[TB] FAIL dec_class%0d_src got %h want %h", c, src_o, 32'(c)); end
      end
      v_i = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back_raw();
      v_i = 1'b1; inst_i = mk(3'd0, 1'b0, 4'd1, 4'd5, 4'd1, 16'h0); addr_i = 32'h200;
      tick();
      inst_i = mk(3'd2, 1'b0, 4'd2, 4'd6, 4'd5, 16'h0); addr_i = 32'h204;
      #1;
      n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("[TB] FAIL raw_stall got %0b want 1", stall_o); end
      tick();
      n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("[TB] FAIL raw_bubble_v_o got %0b want 0", v_o); end
      // Execute now writes back R5.
      ex_wb_i = 1'b1; ex_rd_num_i = 4'd5; ex_rd_data_i = 32'hCAFE_F00D;
      #1;
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL raw_release_stall got %0b want 0", stall_o); end
      tick();
      ex_wb_i = 1'b0;
      n_cmp++; if (v_o !== 1'b1) begin n_err++; $display("[TB] FAIL raw_issue_v_o got %0b want 1", v_o); end
      n_cmp++; if (src_o !== 32'hCAFE_F00D) begin n_err++; $display("[TB] FAIL raw_bypass_src got %h want cafef00d", src_o); end
      n_cmp++; if (rd_num_o !== 4'd6) begin n_err++; $display("[TB] FAIL raw_rd_num got %0d want 6", rd_num_o); end
      n_cmp++; if (origaddr_o !== 32'h204) begin n_err++; $display("[TB] FAIL raw_addr got %h want 204", origaddr_o); end
      v_i = 1'b0;
      tick();
      n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("[TB] FAIL raw_no_dup got %0b want 0", v_o); end
   endtask

   task automatic test_ex_stall();
      v_i = 1'b1; inst_i = mk(3'd4, 1'b0, 4'd0, 4'd1, 4'd2, 16'h0); addr_i = 32'h300;
      tick();
      n_cmp++; if (origaddr_o !== 32'h300) begin n_err++; $display("[TB] FAIL exs_load_addr got %h want 300", origaddr_o); end
      inst_i = mk(3'd3, 1'b1, 4'd5, 4'd9, 4'd0, 16'h0010); addr_i = 32'h304;
      ex_stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("[TB] FAIL exs_stall_%0d got %0b want 1", k, stall_o); end
         tick();
         n_cmp++; if (origaddr_o !== 32'h300) begin n_err++; $display("[TB] FAIL exs_hold_addr_%0d got %h want 300", k, origaddr_o); end
         n_cmp++; if (v_o !== 1'b1) begin n_err++; $display("[TB] FAIL exs_hold_v_%0d got %0b want 1", k, v_o); end
         n_cmp++; if (dopc_o !== 6'b000010) begin n_err++; $display("[TB] FAIL exs_hold_dopc_%0d got %b want 000010", k, dopc_o); end
      end
      ex_stall_i = 1'b0;
      #1;
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL exs_release_stall got %0b want 0", stall_o); end
      tick();
      n_cmp++; if (origaddr_o !== 32'h304) begin n_err++; $display("[TB] FAIL exs_next_addr got %h want 304", origaddr_o); end
      n_cmp++; if (v_o !== 1'b1) begin n_err++; $display("[TB] FAIL exs_next_v got %0b want 1", v_o); end
      n_cmp++; if (rd_num_o !== 4'd9) begin n_err++; $display("[TB] FAIL exs_next_rd got %0d want 9", rd_num_o); end
      n_cmp++; if (src_o !== 32'h10) begin n_err++; $display("[TB] FAIL exs_next_src got %h want 10", src_o); end
      v_i = 1'b0;
      tick();
      n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("[TB] FAIL exs_no_dup got %0b want 0", v_o); end
   endtask

   task automatic test_flush();
      v_i = 1'b1; inst_i = mk(3'd0, 1'b0, 4'd0, 4'd4, 4'd0, 16'h0); addr_i = 32'h400;
      tick();
      inst_i = mk(3'd1, 1'b0, 4'd0, 4'd10, 4'd4, 16'h0); addr_i = 32'h404;
      ex_stall_i = 1'b1; flush_i = 1'b1;
      #1;
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL flush_stall got %0b want 0", stall_o); end
      tick();
      n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("[TB] FAIL flush_v_o got %0b want 0", v_o); end
      n_cmp++; if (wb_o !== 1'b0) begin n_err++; $display("[TB] FAIL flush_wb_o got %0b want 0", wb_o); end
      flush_i = 1'b0; ex_stall_i = 1'b0; v_i = 1'b0;
      tick();
      n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("[TB] FAIL flush_after_v_o got %0b want 0", v_o); end
   endtask

   task automatic test_illegal();
      v_i = 1'b1; inst_i = mk(3'd0, 1'b1, 4'd0, 4'd3, 4'd0, 16'h1); addr_i = 32'h500;
      tick();
      inst_i = mk(3'd7, 1'b0, 4'hF, 4'd3, 4'd3, 16'h0); addr_i = 32'h504;
      #1;
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL ill7_stall got %0b want 0", stall_o); end
      tick();
      n_cmp++; if (v_o !== 1'b1) begin n_err++; $display("[TB] FAIL ill7_v_o got %0b want 1", v_o); end
      n_cmp++; if (illegal_o !== 1'b1) begin n_err++; $display("[TB] FAIL ill7_illegal got %0b want 1", illegal_o); end
      n_cmp++; if (dopc_o !== 6'b0) begin n_err++; $display("[TB] FAIL ill7_dopc got %b want 000000", dopc_o); end
      n_cmp++; if (wb_o !== 1'b0) begin n_err++; $display("[TB] FAIL ill7_wb got %0b want 0", wb_o); end
      inst_i = mk(3'd6, 1'b0, 4'd0, 4'd3, 4'd3, 16'h0); addr_i = 32'h508;
      tick();
      n_cmp++; if (illegal_o !== 1'b1) begin n_err++; $display("[TB] FAIL ill6_illegal got %0b want 1", illegal_o); end
      n_cmp++; if (origaddr_o !== 32'h508) begin n_err++; $display("[TB] FAIL ill6_addr got %h want 508", origaddr_o); end
      inst_i = mk(3'd0, 1'b0, 4'd0, 4'd3, 4'd3, 16'h0); addr_i = 32'h50C;
      #1;
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL ill_after_stall got %0b want 0", stall_o); end
      tick();
      n_cmp++; if (illegal_o !== 1'b0) begin n_err++; $display("[TB] FAIL ill_after_illegal got %0b want 0", illegal_o); end
      n_cmp++; if (v_o !== 1'b1) begin n_err++; $display("[TB] FAIL ill_after_v_o got %0b want 1", v_o); end
   endtask

   task automatic test_reset_mid_stall();
      // Output register holds an R3 writer; present an R3 reader.
      inst_i = mk(3'd2, 1'b0, 4'd0, 4'd11, 4'd3, 16'h0); addr_i = 32'h600;
      #1;
      n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("[TB] FAIL rms_stall got %0b want 1", stall_o); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL rms_release got %0b want 0", stall_o); end
      n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("[TB] FAIL rms_v_o got %0b want 0", v_o); end
      // Registers written earlier (R3, R5) must be cleared.
      inst_i = mk(3'd4, 1'b0, 4'd0, 4'd3, 4'd5, 16'h0); addr_i = 32'h604;
      tick();
      n_cmp++; if (src_o !== 32'h0) begin n_err++; $display("[TB] FAIL rms_rf_r5 got %h want 0", src_o); end
      n_cmp++; if (dest_o !== 32'h0) begin n_err++; $display("[TB] FAIL rms_rf_r3 got %h want 0", dest_o); end
      v_i = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; v_i = 1'b0; inst_i = '0; addr_i = '0;
      flush_i = 1'b0; ex_stall_i = 1'b0;
      ex_wb_i = 1'b0; ex_rd_num_i = '0; ex_rd_data_i = '0;
      test_reset();
      test_decode();
      test_back_to_back_raw();
      test_ex_stall();
      test_flush();
      test_illegal();
      test_reset_mid_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
